wb_host_sequencer: RTL

- Wishbone classic single-beat initiator: the other end of the multiplexer's slave port.
- Accepts read/write commands from a host-side front-end (debug UART / scan bridge) through a valid/ready command FIFO.
- Issues each command as one Wishbone cycle, then returns read data or a timeout error on a valid/ready response channel.
- Handles the slave's 2-cycle registered ack, including the ack staying high after stb drops; no stale ack is ever taken for the next cycle.

---
 rtl/wb_host_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/wb_host_sequencer.sv
// Wishbone classic single-beat initiator. Host commands enter through a small FIFO and
// each one becomes exactly one Wishbone cycle. The read data or a timeout error comes
// back on a valid/ready response channel, in command order.
module wb_host_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned TO_W       = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  output logic        busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
  localparam logic [TO_W-1:0] ToLast  = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StDrain, StResp} state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } cmd_t;

  cmd_t            mem_q [FIFO_DEPTH];
  cmd_t            cmd_in, head;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            cyc_q, cyc_d, we_q, we_d;
  logic [31:0]     adr_q, adr_d, dat_q, dat_d;
  logic            rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0]     rsp_dat_q, rsp_dat_d;
  logic            push, pop;

  assign cmd_in = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat};
  assign head   = mem_q[rd_ptr_q];

  // Ready comes from the registered count, so a pop while full does not admit a push that cycle.
  assign cmd_ready = (count_q != CntFull);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == StIdle) && (count_q != '0);

  // Next-state logic for the FIFO bookkeeping and the bus sequencer.
  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_dat_d   = rsp_dat_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d  = StReq;
          cyc_d    = 1'b1;
          we_d     = head.we;
          adr_d    = head.adr;
          dat_d    = head.dat;
          to_cnt_d = '0;
        end
      end
      StReq: begin
        // Ack takes priority over a timeout landing on the same cycle.
        if (wbm_ack_i) begin
          state_d   = StDrain;
          cyc_d     = 1'b0;
          rsp_dat_d = we_q ? 32'h0 : wbm_dat_i;
          rsp_err_d = 1'b0;
          to_cnt_d  = '0;
        end else if (to_cnt_q == ToLast) begin
          state_d   = StDrain;
          cyc_d     = 1'b0;
          rsp_dat_d = 32'h0;
          rsp_err_d = 1'b1;
          to_cnt_d  = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      StDrain: begin
        // The slave's registered ack lingers after stb drops; wait it out so it is never
        // mistaken for the ack of the next cycle.
        if (!wbm_ack_i) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
        end else if (to_cnt_q == ToLast) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = 32'h0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state, FIFO pointers and all registered outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      to_cnt_q    <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 32'h0;
      dat_q       <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      to_cnt_q    <= to_cnt_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end

  // Command storage.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= cmd_in;
    end
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = 4'hF;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (count_q != '0) || (state_q != StIdle);

endmodule
